// File: rtl/aludec_pkg.sv
// Shared constants for the ALU control decoder: aluop classes, R-type funct codes
// and alucontrol encodings (XOR/NOR are used only when ALUDEC_EXT_OPS_EN is defined).
package aludec_pkg;

    typedef enum logic [1:0] {
        ALUOP_LSW   = 2'b00,
        ALUOP_BEQ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_XOR = 3'b011;
    localparam logic [2:0] CTRL_NOR = 3'b100;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

endpackage

// File: rtl/aludec_core.sv
// Combinational ALU control decode (aluop, funct -> ctrl, illegal).
// Defining ALUDEC_EXT_OPS_EN adds the XOR and NOR R-type decodes.
module aludec_core
    import aludec_pkg::*;
#(
    parameter logic [2:0] ILLEGAL_CTRL = CTRL_ADD
) (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output logic       illegal
);

    // funct is only examined for R-type, so an undriven funct on lw/sw/beq cannot leak X.
    always_comb begin
        ctrl    = ILLEGAL_CTRL;
        illegal = 1'b1;
        case (aluop)
            ALUOP_LSW: begin
                ctrl    = CTRL_ADD;
                illegal = 1'b0;
            end
            ALUOP_BEQ: begin
                ctrl    = CTRL_SUB;
                illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
                    FUNCT_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
                    FUNCT_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
                    FUNCT_OR:  begin ctrl = CTRL_OR;  illegal = 1'b0; end
                    FUNCT_SLT: begin ctrl = CTRL_SLT; illegal = 1'b0; end
`ifdef ALUDEC_EXT_OPS_EN
                    FUNCT_XOR: begin ctrl = CTRL_XOR; illegal = 1'b0; end
                    FUNCT_NOR: begin ctrl = CTRL_NOR; illegal = 1'b0; end
`endif
                    default: begin
                        ctrl    = ILLEGAL_CTRL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl    = ILLEGAL_CTRL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/aludec.sv
// Registered ALU control decoder: one-cycle latency, no backpressure.
// Extended XOR/NOR decodes are enabled by defining ALUDEC_EXT_OPS_EN.
module aludec
    import aludec_pkg::*;
#(
    parameter logic [2:0] ILLEGAL_CTRL = CTRL_ADD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       out_valid,
    output logic       illegal
);

    logic [2:0] w_ctrl;
    logic       w_illegal;
    logic [2:0] r_alucontrol;
    logic       r_out_valid;
    logic       r_illegal;

    aludec_core #(
        .ILLEGAL_CTRL (ILLEGAL_CTRL)
    ) u_core (
        .aluop   (aluop),
        .funct   (funct),
        .ctrl    (w_ctrl),
        .illegal (w_illegal)
    );

    // Decode result is held while idle; only out_valid marks freshness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alucontrol <= 3'b000;
            r_out_valid  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alucontrol <= w_ctrl;
                r_illegal    <= w_illegal;
            end
        end
    end

    assign alucontrol = r_alucontrol;
    assign out_valid  = r_out_valid;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_aludec.sv
// Directed self-checking bench for aludec; expected values are hand-computed constants.
module tb_aludec;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [2:0] alucontrol;
    logic       out_valid;
    logic       illegal;

    int n_assert;
    int n_fail;

    aludec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .out_valid  (out_valid),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] exp_ctrl,
                         input logic exp_v, input logic exp_ill);
        n_assert++;
        assert (alucontrol === exp_ctrl) else begin
            n_fail++;
            $error("FAIL %s alucontrol: observed %b expected %b", tag, alucontrol, exp_ctrl);
        end
        n_assert++;
        assert (out_valid === exp_v) else begin
            n_fail++;
            $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_v);
        end
        n_assert++;
        assert (illegal === exp_ill) else begin
            n_fail++;
            $error("FAIL %s illegal: observed %b expected %b", tag, illegal, exp_ill);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
        in_valid = v;
        aluop    = op;
        funct    = fn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        aluop    = 2'b00;
        funct    = 6'b000000;

        #3;
        check("reset", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_edge", 3'b000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_release", 3'b000, 1'b0, 1'b0);

        drive(1'b1, 2'b00, 6'bxxxxxx);
        check("lsw_xfunct", 3'b010, 1'b1, 1'b0);
        drive(1'b1, 2'b01, 6'bxxxxxx);
        check("beq_xfunct", 3'b110, 1'b1, 1'b0);

        drive(1'b1, 2'b10, 6'b100000);
        check("r_add", 3'b010, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 6'b100010);
        check("r_sub", 3'b110, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 6'b100100);
        check("r_and", 3'b000, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 6'b100101);
        check("r_or", 3'b001, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 6'b101010);
        check("r_slt", 3'b111, 1'b1, 1'b0);

        drive(1'b0, 2'b00, 6'b000000);
        check("hold1_slt", 3'b111, 1'b0, 1'b0);
        drive(1'b0, 2'b01, 6'b111111);
        check("hold2_slt", 3'b111, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b111111);
        check("r_illegal", 3'b010, 1'b1, 1'b1);
        drive(1'b1, 2'b11, 6'b100000);
        check("rsvd", 3'b010, 1'b1, 1'b1);
        drive(1'b0, 2'b00, 6'b000000);
        check("hold_illegal", 3'b010, 1'b0, 1'b1);

`ifdef ALUDEC_EXT_OPS_EN
        drive(1'b1, 2'b10, 6'b100110);
        check("r_xor", 3'b011, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 6'b100111);
        check("r_nor", 3'b100, 1'b1, 1'b0);
`else
        drive(1'b1, 2'b10, 6'b100110);
        check("r_xor_off", 3'b010, 1'b1, 1'b1);
        drive(1'b1, 2'b10, 6'b100111);
        check("r_nor_off", 3'b010, 1'b1, 1'b1);
`endif

        drive(1'b1, 2'b10, 6'b100100);
        check("pre_reset_and", 3'b000, 1'b1, 1'b0);
        drive(1'b1, 2'b01, 6'b000000);
        check("pre_reset_sub", 3'b110, 1'b1, 1'b0);

        // Pulse reset between edges while a decode is in flight.
        aluop = 2'b10;
        funct = 6'b101010;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_discard", 3'b000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", 3'b111, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aludec.md
ALUDEC -- requirements
Module: aludec

Interface
REQ-001 Parameter: ILLEGAL_CTRL, default 3'b010 (ADD); alucontrol value issued for any illegal decode.
REQ-002 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid: input, 1 bit, aluop/funct sample strobe.
REQ-006 Port aluop: input, 2 bits, operation class from main decoder.
REQ-007 Port funct: input, 6 bits, R-type function field.
REQ-008 Port alucontrol: output, 3 bits, registered ALU operation select.
REQ-009 Port out_valid: output, 1 bit, alucontrol holds a fresh decode.
REQ-010 Port illegal: output, 1 bit, fresh decode was illegal; meaningful only while out_valid=1.

Function
REQ-011 Decode SHALL be: aluop=00 -> 010 (ADD, lw/sw/addi); aluop=01 -> 110 (SUB, beq); funct is ignored for both, including X/Z funct.
REQ-012 aluop=10 SHALL decode funct: 100000 -> 010 ADD; 100010 -> 110 SUB; 100100 -> 000 AND; 100101 -> 001 OR; 101010 -> 111 SLT.
REQ-013 aluop=10 with any other funct SHALL yield ILLEGAL_CTRL and illegal=1.
REQ-014 aluop=11 is reserved and SHALL yield ILLEGAL_CTRL and illegal=1.
REQ-015 Latency SHALL be exactly 1 cycle: on a rising clk edge with in_valid=1, alucontrol/illegal load the decode and out_valid=1.
REQ-016 On a rising edge with in_valid=0, out_valid SHALL go to 0 and alucontrol/illegal SHALL hold their values.
REQ-017 Back-to-back in_valid=1 SHALL produce one decode per cycle with no bubbles; there is no backpressure.
REQ-018 Outputs SHALL never be X once reset has been applied, even when funct is X and aluop is 00/01.

Reset
REQ-019 rst_n=0 SHALL immediately set alucontrol=000, out_valid=0, illegal=0, independent of clk.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight decode; the first decode after release occurs on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-021 Macro ALUDEC_EXT_OPS_EN, when defined, SHALL add aluop=10 decodes: funct 100110 -> 011 (XOR), 100111 -> 100 (NOR), each with illegal=0.
REQ-022 Without ALUDEC_EXT_OPS_EN, funct 100110 and 100111 SHALL be illegal per REQ-013; all other behaviour is identical.

Structure
REQ-023 Shared package aludec_pkg SHALL hold the aluop constants (LSW, BEQ, RTYPE, RSVD), the funct constants, and the alucontrol constants (AND, OR, ADD, SUB, SLT, XOR, NOR).
REQ-024 The design SHALL contain one purely combinational sub-module, aludec_core (aluop, funct -> ctrl, illegal), instantiated by aludec ahead of the output register.

Verification
REQ-025 Reset, then aluop=00, funct=xxxxxx, in_valid=1 -> after 1 edge: alucontrol=010, out_valid=1, illegal=0.
REQ-026 aluop=01, funct=xxxxxx -> alucontrol=110, illegal=0.
REQ-027 aluop=10 with funct 100000/100010/100100/100101/101010 over consecutive cycles -> alucontrol 010/110/000/001/111, each one cycle later, out_valid held at 1.
REQ-028 aluop=10, funct=111111 -> alucontrol=ILLEGAL_CTRL (010), illegal=1; aluop=11 -> same.
REQ-029 in_valid dropped for 2 cycles -> out_valid=0 and alucontrol held; rst_n pulsed low between clk edges -> outputs 000/0/0 at once.
REQ-030 funct=100110: with ALUDEC_EXT_OPS_EN -> 011, illegal=0; without it -> 010, illegal=1.
